// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle RV32M multiply/divide unit that sits beside the EX-stage ALU.
// Unsigned magnitudes go through a radix-2 shift-add multiplier or a restoring divider.
// Each runs for DATA_WIDTH cycles and is followed by one sign-fix cycle and a one-cycle done.
// Optional feature macro: MDU_DIV_EN. When it is defined, the divider is built.
// When it is undefined, divide opcodes complete at once with Result=0 and illegal=1.
module mdu_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  busy,
    output logic                  done,
    output logic                  stall,
    output logic                  illegal
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state, nextState;
    logic [CW-1:0]   count;
    logic [2:0]      opReg;
    logic [W-1:0]    hiReg, loReg, operandReg;
    logic            negQuot, illegalReg;
`ifdef MDU_DIV_EN
    logic            negRem;
`endif

    logic            acceptStart, signedA, signedB, signA, signB;
    logic [W-1:0]    absA, absB;
    logic            fastPath, fastIllegal;
    logic [W-1:0]    fastResult;
    logic [W:0]      mulSum;
    logic [W-1:0]    stepHi, stepLo;
    logic [2*W-1:0]  prodFix;
    logic [W-1:0]    fixResult;

    assign acceptStart = start & ((state == IDLE) | (state == DONE));

    // Operand sign handling and the fast-path decision for the op being offered.
    always_comb begin
        signedA = (Funct3 == 3'b001) | (Funct3 == 3'b010) | (Funct3 == 3'b100) | (Funct3 == 3'b110);
        signedB = (Funct3 == 3'b001) | (Funct3 == 3'b100) | (Funct3 == 3'b110);
        signA   = signedA & SrcA[W-1];
        signB   = signedB & SrcB[W-1];
        absA    = signA ? -SrcA : SrcA;
        absB    = signB ? -SrcB : SrcB;
`ifdef MDU_DIV_EN
        fastIllegal = 1'b0;
        fastPath    = 1'b0;
        fastResult  = '0;
        if (Funct3[2] && (SrcB == '0)) begin
            fastPath   = 1'b1;
            fastResult = Funct3[1] ? SrcA : '1;
        end else if (Funct3[2] && !Funct3[0] && (SrcA == {1'b1, {(W-1){1'b0}}}) && (&SrcB)) begin
            fastPath   = 1'b1;
            fastResult = Funct3[1] ? '0 : SrcA;
        end
`else
        fastIllegal = Funct3[2];
        fastPath    = Funct3[2];
        fastResult  = '0;
`endif
    end

    // One multiply or divide iteration, plus the final sign correction and half select.
    always_comb begin
        mulSum = {1'b0, hiReg} + {1'b0, operandReg};
        if (loReg[0]) begin
            stepHi = mulSum[W:1];
            stepLo = {mulSum[0], loReg[W-1:1]};
        end else begin
            stepHi = {1'b0, hiReg[W-1:1]};
            stepLo = {hiReg[0], loReg[W-1:1]};
        end
        prodFix   = negQuot ? -{hiReg, loReg} : {hiReg, loReg};
        fixResult = (opReg[1:0] == 2'b00) ? prodFix[W-1:0] : prodFix[2*W-1:W];
`ifdef MDU_DIV_EN
        if (opReg[2]) begin
            if ({hiReg, loReg[W-1]} >= {1'b0, operandReg}) begin
                stepHi = {hiReg[W-2:0], loReg[W-1]} - operandReg;
                stepLo = {loReg[W-2:0], 1'b1};
            end else begin
                stepHi = {hiReg[W-2:0], loReg[W-1]};
                stepLo = {loReg[W-2:0], 1'b0};
            end
            if (opReg[1]) begin
                fixResult = negRem ? -hiReg : hiReg;
            end else begin
                fixResult = negQuot ? -loReg : loReg;
            end
        end
`else
        if (opReg[2]) begin
            fixResult = '0;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        nextState = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (acceptStart) begin
                    nextState = fastPath ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (count == CW'(1)) begin
                    nextState = FIX;
                end
            end
            FIX: begin
                busy      = 1'b1;
                nextState = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (acceptStart) begin
                    nextState = fastPath ? DONE : CALC;
                end else begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
        stall   = busy | (acceptStart & ~fastPath);
        illegal = done & illegalReg;
    end

    // Operand latch, iteration datapath, iteration counter and result register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count      <= '0;
            opReg      <= '0;
            hiReg      <= '0;
            loReg      <= '0;
            operandReg <= '0;
            negQuot    <= 1'b0;
            illegalReg <= 1'b0;
            Result     <= '0;
`ifdef MDU_DIV_EN
            negRem     <= 1'b0;
`endif
        end else if (acceptStart) begin
            opReg      <= Funct3;
            negQuot    <= signA ^ signB;
            illegalReg <= fastIllegal;
`ifdef MDU_DIV_EN
            negRem     <= signA;
`endif
            hiReg      <= '0;
            loReg      <= absA;
            operandReg <= absB;
            count      <= fastPath ? '0 : CW'(W);
            if (fastPath) begin
                Result <= fastResult;
            end
        end else if (state == CALC) begin
            hiReg <= stepHi;
            loReg <= stepLo;
            count <= count - CW'(1);
        end else if (state == FIX) begin
            Result <= fixResult;
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: randomized self-checking bench for mdu_sequencer (32-bit).
// Expected results come from a plain-arithmetic RV32M model. Latency and stall behaviour
// are checked against the fixed cycle counts of the unit.
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  Funct3;
    logic [31:0] SrcA, SrcB;
    logic [31:0] Result;
    logic        busy, done, stall, illegal;

    int          passCount = 0;
    int          checkCount = 0;
    logic [31:0] lastExp;
    bit          inDone;

    mdu_sequencer #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .Funct3(Funct3),
        .SrcA(SrcA), .SrcB(SrcB), .Result(Result),
        .busy(busy), .done(done), .stall(stall), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Global guard so the run always ends.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end else begin
            passCount++;
        end
    endtask

    // RV32M reference: result, illegal flag and cycles from start to done.
    task automatic refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] res, output bit ill, output int lat);
        logic [63:0] p;
        int sa, sb;
        ill = 1'b0;
        lat = 34;
        res = '0;
        sa  = a;
        sb  = b;
        case (op)
            3'd0: begin p = {32'b0, a} * {32'b0, b};           res = p[31:0];  end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; res = p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b};     res = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b};           res = p[63:32]; end
            default: begin
`ifdef MDU_DIV_EN
                if (b == 32'd0) begin
                    lat = 1;
                    res = op[1] ? a : 32'hFFFF_FFFF;
                end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lat = 1;
                    res = op[1] ? 32'd0 : a;
                end else begin
                    case (op)
                        3'd4:    res = sa / sb;
                        3'd5:    res = a / b;
                        3'd6:    res = sa % sb;
                        default: res = a % b;
                    endcase
                end
`else
                lat = 1;
                res = '0;
                ill = 1'b1;
`endif
            end
        endcase
    endtask

    // Issue one op after gap idle cycles and follow it to done, checking every observable.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input bit junk, input int gap);
        logic [31:0] expRes;
        bit          expIll;
        int          expLat;
        int          doneAt;
        int          busyCycles;
        refModel(op, a, b, expRes, expIll, expLat);
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            inDone = 1'b0;
        end
        @(negedge clk);
        if (inDone) begin
            checkOutput("b2b_done_high", 32'(done), 32'd1);
            checkOutput("b2b_old_result", Result, lastExp);
        end
        Funct3 = op;
        SrcA   = a;
        SrcB   = b;
        start  = 1'b1;
        #1;
        checkOutput("stall_at_start", 32'(stall), (expLat > 1) ? 32'd1 : 32'd0);
        @(posedge clk);
        #1;
        start      = 1'b0;
        doneAt     = 0;
        busyCycles = 0;
        for (int k = 1; k <= 40; k++) begin
            if (busy) busyCycles++;
            if (done) begin
                doneAt = k;
                break;
            end
            if (expLat > 1 && k == expLat - 1) begin
                checkOutput("result_held_busy", Result, lastExp);
            end
            SrcA = $urandom;
            SrcB = $urandom;
            if (junk && k >= 2 && k <= 30) begin
                start  = 1'($urandom_range(0, 1));
                Funct3 = 3'($urandom_range(0, 7));
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        checkOutput("latency", 32'(doneAt), 32'(expLat));
        checkOutput("result", Result, expRes);
        checkOutput("illegal", 32'(illegal), 32'(expIll));
        checkOutput("busy_cycles", 32'(busyCycles), (expLat > 1) ? 32'd33 : 32'd0);
        checkOutput("stall_in_done", 32'(stall), 32'd0);
        lastExp = expRes;
        inDone  = (doneAt != 0);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'd1;
            4:       return 32'($urandom_range(0, 50));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int sawDone;
        reset   = 1'b0;
        start   = 1'b0;
        Funct3  = '0;
        SrcA    = '0;
        SrcB    = '0;
        lastExp = '0;
        inDone  = 1'b0;
        $display("[TB] starting mdu_sequencer bench");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_result", Result, 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_illegal", 32'(illegal), 32'd0);
        checkOutput("reset_stall", 32'(stall), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed cases, some issued back to back from DONE.
        applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1, 1);
        applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
        applyStimulus(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 2);
        applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
        applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, 1);
        applyStimulus(3'd5, 32'd100, 32'd7, 1'b1, 0);
        applyStimulus(3'd7, 32'd100, 32'd7, 1'b0, 0);
        applyStimulus(3'd5, 32'd5, 32'd0, 1'b0, 1);
        applyStimulus(3'd6, 32'd5, 32'd0, 1'b0, 0);
        applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        applyStimulus(3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 0);

        // Abort a multiply in its tenth busy cycle with an asynchronous reset.
        @(negedge clk);
        Funct3 = 3'd0;
        SrcA   = $urandom;
        SrcB   = $urandom;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_result", Result, 32'd0);
        @(negedge clk);
        reset   = 1'b1;
        lastExp = '0;
        inDone  = 1'b0;
        sawDone = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (done) sawDone++;
        end
        checkOutput("abort_no_done", 32'(sawDone), 32'd0);
        applyStimulus(3'd0, 32'd3, 32'd4, 1'b0, 0);

        // Randomized ops with random gaps, edge-heavy operands and ignored start pulses.
        for (int n = 0; n < 24; n++) begin
            applyStimulus(3'($urandom_range(0, 7)), pickOperand(), pickOperand(),
                          1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
